// File: rtl/dmem_io_bus.sv
// -----------------------------------------------------------------------------
// dmem_io_bus
//
// Data-memory and memory-mapped I/O block for the 16-bit LEGLite CPUs.
// Serves the CPU data port from a word RAM plus an eight-register I/O window:
// a 7-segment display register, debounced switches with rising-edge capture,
// and a free-running compare timer. Reads are combinational so single-cycle
// cores can use the block unchanged.
//
// Parameters
//   WIDTH     data and address width
//   DEPTH     RAM words (power of two, DEPTH <= IO_BASE)
//   NSW       number of switch inputs (1..WIDTH)
//   DEBOUNCE  consecutive stable synchronized cycles to accept a switch change
//   IO_BASE   word address of I/O register 0 (window is IO_BASE..IO_BASE+7)
//
// Ports
//   clock       in   single clock, all state updates on its rising edge
//   reset       in   synchronous, active-high
//   draddr      in   word address
//   dwdata      in   write data
//   dwrite      in   write enable, sampled at the rising edge
//   dread       in   read enable; drdata is 0 while low
//   io_sw       in   raw asynchronous switch inputs
//   drdata      out  combinational read data
//   io_display  out  display segment register
//   irq         out  registered OR of the enabled status flags
//
// Bus protocol: there is no handshake. A write happens on every rising edge
// where dwrite is high; a read is a pure combinational lookup qualified by
// dread and has no side effects.
//
// I/O map (offset from IO_BASE)
//   0 DISP    r/w   bits[6:0] drive io_display
//   1 SWSTATE ro    debounced switch levels
//   2 SWEDGE  r/w1c sticky rising-edge capture of the debounced levels
//   3 TCOUNT  r/w   timer count
//   4 TCMP    r/w   timer compare value
//   5 TCTRL   r/w   bit0 enable, bit1 auto-reload, bit2 match irq en,
//                   bit3 edge irq en
//   6 STATUS  r/w1c bit0 MATCH, bit1 EDGE
//   7 reserved, reads 0, writes ignored
// -----------------------------------------------------------------------------
module dmem_io_bus #(
  parameter int              WIDTH    = 16,
  parameter int              DEPTH    = 128,
  parameter int              NSW      = 2,
  parameter int              DEBOUNCE = 4,
  parameter logic [WIDTH-1:0] IO_BASE = 16'hFFF0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] draddr,
  input  logic [WIDTH-1:0] dwdata,
  input  logic             dwrite,
  input  logic             dread,
  input  logic [NSW-1:0]   io_sw,
  output logic [WIDTH-1:0] drdata,
  output logic [6:0]       io_display,
  output logic             irq
);

  localparam int AW = $clog2(DEPTH);
  // Wide enough to hold DEBOUNCE-1 even when DEBOUNCE is 1.
  localparam int CW = $clog2(DEBOUNCE + 1);
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE - 1);

  localparam logic [2:0] OFF_DISP    = 3'd0;
  localparam logic [2:0] OFF_SWSTATE = 3'd1;
  localparam logic [2:0] OFF_SWEDGE  = 3'd2;
  localparam logic [2:0] OFF_TCOUNT  = 3'd3;
  localparam logic [2:0] OFF_TCMP    = 3'd4;
  localparam logic [2:0] OFF_TCTRL   = 3'd5;
  localparam logic [2:0] OFF_STATUS  = 3'd6;

  // Window limits are compared one bit wider so IO_BASE+7 cannot wrap.
  localparam logic [WIDTH:0] IO_LO  = {1'b0, IO_BASE};
  localparam logic [WIDTH:0] IO_HI  = IO_LO + (WIDTH+1)'(7);
  localparam logic [WIDTH:0] RAM_HI = (WIDTH+1)'(DEPTH);

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  logic [WIDTH:0] addr_x;
  logic           ram_sel;
  logic           io_sel;
  logic [2:0]     io_off;
  logic [AW-1:0]  ram_idx;

  assign addr_x  = {1'b0, draddr};
  assign ram_sel = addr_x < RAM_HI;
  assign io_sel  = (addr_x >= IO_LO) && (addr_x <= IO_HI);
  // The low three bits of (draddr - IO_BASE) depend only on the low three
  // bits of each operand, so the offset needs no full-width subtract.
  assign io_off  = draddr[2:0] - IO_BASE[2:0];
  assign ram_idx = draddr[AW-1:0];

  logic io_wr;
  logic wr_disp, wr_swedge, wr_tcount, wr_tcmp, wr_tctrl, wr_status;

  assign io_wr     = dwrite && io_sel;
  assign wr_disp   = io_wr && (io_off == OFF_DISP);
  assign wr_swedge = io_wr && (io_off == OFF_SWEDGE);
  assign wr_tcount = io_wr && (io_off == OFF_TCOUNT);
  assign wr_tcmp   = io_wr && (io_off == OFF_TCMP);
  assign wr_tctrl  = io_wr && (io_off == OFF_TCTRL);
  assign wr_status = io_wr && (io_off == OFF_STATUS);

  // ---------------------------------------------------------------------------
  // RAM: not reset, so a write coinciding with reset still lands.
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (dwrite && ram_sel) begin
      mem[ram_idx] <= dwdata;
    end
  end

  // ---------------------------------------------------------------------------
  // I/O registers
  // ---------------------------------------------------------------------------
  logic [6:0]       disp;
  logic [NSW-1:0]   sync1;
  logic [NSW-1:0]   sync2;
  logic [NSW-1:0]   sw_state;
  logic [NSW-1:0]   sw_edge;
  logic [CW-1:0]    db_cnt [NSW];
  logic [WIDTH-1:0] tcount;
  logic [WIDTH-1:0] tcmp;
  logic [3:0]       tctrl;
  logic             stat_match;
  logic             stat_edge;

  // Debounce acceptance: a bit is accepted on the edge where it has already
  // differed for DEBOUNCE-1 cycles and still differs, i.e. the count would
  // reach DEBOUNCE on this edge.
  logic [NSW-1:0] sw_accept;
  logic [NSW-1:0] sw_rise;
  logic [NSW-1:0] edge_clr;

  always_comb begin
    sw_accept = '0;
    sw_rise   = '0;
    for (int i = 0; i < NSW; i++) begin
      sw_accept[i] = (sync2[i] != sw_state[i]) && (db_cnt[i] == DB_LAST);
      sw_rise[i]   = sw_accept[i] && sync2[i];
    end
  end

  assign edge_clr = wr_swedge ? dwdata[NSW-1:0] : '0;

  logic match_hit;
  assign match_hit = tctrl[0] && (tcount == tcmp);

  always_ff @(posedge clock) begin
    if (reset) begin
      disp       <= '0;
      sync1      <= '0;
      sync2      <= '0;
      sw_state   <= '0;
      sw_edge    <= '0;
      tcount     <= '0;
      tcmp       <= '0;
      tctrl      <= '0;
      stat_match <= 1'b0;
      stat_edge  <= 1'b0;
      irq        <= 1'b0;
      for (int i = 0; i < NSW; i++) begin
        db_cnt[i] <= '0;
      end
    end else begin
      if (wr_disp) begin
        disp <= dwdata[6:0];
      end

      // Two-flop synchronizer followed by a per-bit debounce counter.
      sync1 <= io_sw;
      sync2 <= sync1;
      for (int i = 0; i < NSW; i++) begin
        if (sync2[i] == sw_state[i]) begin
          db_cnt[i] <= '0;
        end else if (sw_accept[i]) begin
          db_cnt[i]   <= '0;
          sw_state[i] <= sync2[i];
        end else begin
          db_cnt[i] <= db_cnt[i] + CW'(1);
        end
      end

      // Sticky flags: a new set on the same edge as a write-1-clear wins.
      sw_edge    <= (sw_edge & ~edge_clr) | sw_rise;
      stat_edge  <= (stat_edge & ~(wr_status & dwdata[1])) | (|sw_rise);
      stat_match <= (stat_match & ~(wr_status & dwdata[0])) | match_hit;

      if (wr_tcmp) begin
        tcmp <= dwdata;
      end
      if (wr_tctrl) begin
        tctrl <= dwdata[3:0];
      end

      // A CPU write to TCOUNT takes priority over counting and reload.
      if (wr_tcount) begin
        tcount <= dwdata;
      end else if (match_hit && tctrl[1]) begin
        tcount <= '0;
      end else if (tctrl[0]) begin
        tcount <= tcount + WIDTH'(1);
      end

      // Registered from the flag registers, so irq trails a flag by one edge.
      irq <= (stat_match & tctrl[2]) | (stat_edge & tctrl[3]);
    end
  end

  assign io_display = disp;

  // ---------------------------------------------------------------------------
  // Combinational read mux
  // ---------------------------------------------------------------------------
  always_comb begin
    drdata = '0;
    if (dread) begin
      if (ram_sel) begin
        drdata = mem[ram_idx];
      end else if (io_sel) begin
        case (io_off)
          OFF_DISP:    drdata[6:0]     = disp;
          OFF_SWSTATE: drdata[NSW-1:0] = sw_state;
          OFF_SWEDGE:  drdata[NSW-1:0] = sw_edge;
          OFF_TCOUNT:  drdata          = tcount;
          OFF_TCMP:    drdata          = tcmp;
          OFF_TCTRL:   drdata[3:0]     = tctrl;
          OFF_STATUS:  drdata[1:0]     = {stat_edge, stat_match};
          default:     drdata          = '0;
        endcase
      end
    end
  end

endmodule
